// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared encodings for the ALU/datapath controller.
//   - FSM state encoding (3-bit)
//   - instruction opcode/op constants
//   - ALUop codes, nsel one-hot register selects, vsel write-back codes
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WRITE_IMM = 3'd2,
        ST_GET_A     = 3'd3,
        ST_GET_B     = 3'd4,
        ST_EXEC      = 3'd5,
        ST_WRITE_REG = 3'd6
    } state_t;

    // opcode field IR[15:13]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op field IR[12:11]
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // ALUop codes
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    // register select, one-hot
    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    // write-back source
    localparam logic [1:0] VSEL_C      = 2'b00;
    localparam logic [1:0] VSEL_SXIMM8 = 2'b01;

endpackage

// File: rtl/alu_ctrl_fsm_instr_dec.sv
// instr_dec: purely combinational field extractor for the controller.
//   i: ir      - latched instruction register
//   o: opcode, op, sh, sximm8 (imm8 sign-extended to WIDTH)
//   o: class flags is_mov_imm, is_mov_reg, is_alu, is_cmp, skip_a
// Register-number fields are not needed by the controller (the datapath
// decodes them from nsel), so they are deliberately left unconsumed.
module instr_dec
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [15:0]      ir,
    output logic [2:0]       opcode,
    output logic [1:0]       op,
    output logic [1:0]       sh,
    output logic [WIDTH-1:0] sximm8,
    output logic             is_mov_imm,
    output logic             is_mov_reg,
    output logic             is_alu,
    output logic             is_cmp,
    output logic             skip_a
);

    logic [2:0] w_unused_rn;

    assign opcode      = ir[15:13];
    assign op          = ir[12:11];
    assign sh          = ir[4:3];
    assign sximm8      = {{(WIDTH-8){ir[7]}}, ir[7:0]};
    assign w_unused_rn = ir[10:8];

    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_alu     = (opcode == OPC_ALU);
    assign is_cmp     = is_alu && (op == OP_CMP);
    // single-operand instructions only need the B path
    assign skip_a     = is_mov_reg || (is_alu && (op == OP_MVN));

endmodule

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle controller driving the 16-bit ALU/datapath.
//   i: clk, reset (sync, active-high), s (start), in (instruction)
//   o: w (ready), nsel/vsel/write (register file), loada/loadb/loadc/loads,
//      asel/bsel/ALUop/shift (ALU path), sximm8 (sign-extended IR[7:0])
// Moore machine: every output is a function of the state register and IR.
module alu_ctrl_fsm
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [15:0]      in,
    output logic             w,
    output logic [2:0]       nsel,
    output logic [1:0]       vsel,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       ALUop,
    output logic [1:0]       shift,
    output logic [WIDTH-1:0] sximm8
);

    state_t      r_state, w_next;
    logic [15:0] r_ir;

    logic [2:0]  w_opcode;
    logic [1:0]  w_op, w_sh;
    logic        w_is_mov_imm, w_is_mov_reg, w_is_alu, w_is_cmp, w_skip_a;

    instr_dec #(.WIDTH(WIDTH)) u_dec (
        .ir         (r_ir),
        .opcode     (w_opcode),
        .op         (w_op),
        .sh         (w_sh),
        .sximm8     (sximm8),
        .is_mov_imm (w_is_mov_imm),
        .is_mov_reg (w_is_mov_reg),
        .is_alu     (w_is_alu),
        .is_cmp     (w_is_cmp),
        .skip_a     (w_skip_a)
    );

    // IR only loads on an accepted start, so in need not be held afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_WAIT;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_WAIT && s)
                r_ir <= in;
        end
    end

    always_comb begin
        w_next = r_state;
        w      = 1'b0;
        nsel   = NSEL_NONE;
        vsel   = VSEL_C;
        write  = 1'b0;
        loada  = 1'b0;
        loadb  = 1'b0;
        loadc  = 1'b0;
        loads  = 1'b0;
        asel   = 1'b0;
        bsel   = 1'b0;
        ALUop  = ALU_ADD;
        shift  = 2'b00;

        case (r_state)
            ST_WAIT: begin
                w = 1'b1;
                if (s)
                    w_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_is_mov_imm)
                    w_next = ST_WRITE_IMM;
                else if (w_skip_a)
                    w_next = ST_GET_B;
                else if (w_is_alu)
                    w_next = ST_GET_A;
                else
                    w_next = ST_WAIT;   // undefined: drop silently
            end
            ST_WRITE_IMM: begin
                nsel   = NSEL_RN;
                vsel   = VSEL_SXIMM8;
                write  = 1'b1;
                w_next = ST_WAIT;
            end
            ST_GET_A: begin
                nsel   = NSEL_RN;
                loada  = 1'b1;
                w_next = ST_GET_B;
            end
            ST_GET_B: begin
                nsel   = NSEL_RM;
                loadb  = 1'b1;
                shift  = w_sh;
                w_next = ST_EXEC;
            end
            ST_EXEC: begin
                shift = w_sh;
                // MOV reg is computed as 0 + shifted B
                asel  = w_is_mov_reg;
                ALUop = w_is_mov_reg ? ALU_ADD : w_op;
                if (w_is_cmp) begin
                    loads  = 1'b1;
                    w_next = ST_WAIT;
                end else begin
                    loadc  = 1'b1;
                    w_next = ST_WRITE_REG;
                end
            end
            ST_WRITE_REG: begin
                nsel   = NSEL_RD;
                vsel   = VSEL_C;
                write  = 1'b1;
                w_next = ST_WAIT;
            end
            default: w_next = ST_WAIT;
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
module tb_alu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset, s;
    logic [15:0] in_r;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  nsel;
    logic [1:0]  vsel, ALUop, shift;
    logic [15:0] sximm8;

    int n_chk  = 0;
    int n_pass = 0;

    alu_ctrl_fsm #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .s(s), .in(in_r),
        .w(w), .nsel(nsel), .vsel(vsel), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .ALUop(ALUop), .shift(shift),
        .sximm8(sximm8)
    );

    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {w, nsel, vsel, write, loada, loadb, loadc, loads,
                  asel, bsel, ALUop, shift};

    function automatic logic [16:0] mk(
        input logic e_w, input logic [2:0] e_nsel, input logic [1:0] e_vsel,
        input logic e_wr, input logic e_la, input logic e_lb, input logic e_lc,
        input logic e_ls, input logic e_as, input logic [1:0] e_alu,
        input logic [1:0] e_sh);
        return {e_w, e_nsel, e_vsel, e_wr, e_la, e_lb, e_lc, e_ls,
                e_as, 1'b0, e_alu, e_sh};
    endfunction

    task automatic chk(input string tag, input logic [16:0] o, input logic [16:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // present instruction for one WAIT cycle, then advance into DECODE
    task automatic start(input logic [15:0] instr);
        in_r = instr;
        s    = 1'b1;
        cyc();
        s    = 1'b0;
        in_r = 16'h5A5A;
    endtask

    logic [16:0] E_WAIT, E_IDLE;

    initial begin
        E_WAIT = mk(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        E_IDLE = mk(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);

        // 1: reset with s high, then undefined 0x0000
        reset = 1'b1; s = 1'b1; in_r = 16'h0000;
        cyc(); cyc();
        chk("rst_out", obs, E_WAIT);
        chk("rst_sximm8", {1'b0, sximm8}, 17'h0);
        reset = 1'b0;
        cyc(); s = 1'b0;
        chk("undef_decode", obs, E_IDLE);
        cyc();
        chk("undef_back_wait", obs, E_WAIT);

        // 2: MOV R3,#-5
        chk("movi_T_wait", obs, E_WAIT);
        start(16'hD3FB);
        chk("movi_decode", obs, E_IDLE);
        cyc();
        chk("movi_write", obs, mk(0, 3'b001, 2'b01, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        chk("movi_sximm8", {1'b0, sximm8}, {1'b0, 16'hFFFB});
        cyc();
        chk("movi_done", obs, E_WAIT);

        // 3: ADD R2,R1,R0,LSL
        start(16'hA148);
        chk("add_decode", obs, E_IDLE);
        cyc();
        chk("add_get_a", obs, mk(0, 3'b001, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        cyc();
        chk("add_get_b", obs, mk(0, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01));
        cyc();
        chk("add_exec", obs, mk(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01));
        cyc();
        chk("add_write", obs, mk(0, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        chk("add_sximm8", {1'b0, sximm8}, {1'b0, 16'h0048});
        cyc();
        chk("add_done", obs, E_WAIT);

        // 4: CMP R5,R6
        start(16'hAD06);
        chk("cmp_decode", obs, E_IDLE);
        cyc();
        chk("cmp_get_a", obs, mk(0, 3'b001, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        cyc();
        chk("cmp_get_b", obs, mk(0, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
        cyc();
        chk("cmp_exec", obs, mk(0, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00));
        cyc();
        chk("cmp_done", obs, E_WAIT);

        // 5: MOV R7,R4,sh=10
        start(16'hC0F4);
        chk("movr_decode", obs, E_IDLE);
        cyc();
        chk("movr_get_b", obs, mk(0, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b10));
        cyc();
        chk("movr_exec", obs, mk(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 2'b10));
        chk("movr_sximm8", {1'b0, sximm8}, {1'b0, 16'hFFF4});
        cyc();
        chk("movr_write", obs, mk(0, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        cyc();
        chk("movr_done", obs, E_WAIT);

        // MVN R7,R0 and an undefined 111 opcode
        start(16'hB8E0);
        cyc();
        chk("mvn_get_b", obs, mk(0, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
        cyc();
        chk("mvn_exec", obs, mk(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0, 2'b11, 2'b00));
        cyc();
        chk("mvn_write", obs, mk(0, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        cyc();
        chk("mvn_done", obs, E_WAIT);
        start(16'hE7FF);
        chk("undef2_decode", obs, E_IDLE);
        cyc();
        chk("undef2_done", obs, E_WAIT);

        // 6: reset during GET_B of ADD
        start(16'hA148);
        cyc(); cyc();
        chk("abort_get_b", obs, mk(0, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01));
        reset = 1'b1; s = 1'b1; in_r = 16'hD3FB;
        cyc();
        chk("abort_wait", obs, E_WAIT);
        chk("abort_ir_clr", {1'b0, sximm8}, 17'h0);
        reset = 1'b0;

        // s held high: two back-to-back MOV imm
        cyc();
        chk("b2b1_decode", obs, E_IDLE);
        cyc();
        chk("b2b1_write", obs, mk(0, 3'b001, 2'b01, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        cyc();
        chk("b2b1_wait", obs, E_WAIT);
        cyc();
        chk("b2b2_decode", obs, E_IDLE);
        s = 1'b0;
        cyc();
        chk("b2b2_write", obs, mk(0, 3'b001, 2'b01, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        chk("b2b2_sximm8", {1'b0, sximm8}, {1'b0, 16'hFFFB});
        cyc();
        chk("b2b2_wait", obs, E_WAIT);
        cyc();
        chk("idle_stays", obs, E_WAIT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
Multi-cycle controller that sits on the driving side of the 16-bit ALU/datapath interface. It accepts one 16-bit instruction per start handshake, decodes it, and sequences register-file reads, ALU operation select, shifter control, status load and write-back. Its outputs drive the datapath's load strobes, select muxes and ALUop directly, making it the initiator counterpart of the ALU.

Parameters:
WIDTH, 16, datapath word width; sets the width of sximm8.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
s  input  1  start; sampled only in WAIT
in  input  16  instruction; latched into internal IR when s is accepted
w  output  1  high only in WAIT (ready for next instruction)
nsel  output  3  register select, one-hot: 001=Rn, 010=Rd, 100=Rm, 000=none
vsel  output  2  write-back source: 00=ALU result (C), 01=sximm8, 1x reserved (never driven)
write  output  1  register-file write strobe
loada  output  1  load A register
loadb  output  1  load B register
loadc  output  1  load C (result) register
loads  output  1  load status (Z) register
asel  output  1  1 forces ALU A input to zero
bsel  output  1  B-input source select; always 0 from this block
ALUop  output  2  00 add, 01 sub, 10 and, 11 not-B
shift  output  2  shifter control for B operand
sximm8  output  WIDTH  IR[7:0] sign-extended to WIDTH

Behaviour:
- Instruction fields (from IR): opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
- Supported instructions:
  - 110/10: MOV Rn,#imm8
  - 110/00: MOV Rd,Rm{,sh}
  - 101/00: ADD Rd,Rn,Rm{,sh}
  - 101/01: CMP Rn,Rm{,sh}
  - 101/10: AND Rd,Rn,Rm{,sh}
  - 101/11: MVN Rd,Rm{,sh}
- Reset: state=WAIT and IR=0. w=1; every other output 0 (sximm8=0).
- Moore outputs from the state register plus IR. Any output not listed for a state is 0.
- State WAIT:
  - w=1.
  - If s=1, latch in->IR and go to DECODE. Otherwise stay.
- State DECODE:
  - 110/10 -> WRITE_IMM
  - 110/00 and 101/11 -> GET_B
  - other 101/xx -> GET_A
  - anything else -> WAIT, with no strobes.
- State WRITE_IMM: nsel=001, vsel=01, write=1 -> WAIT.
- State GET_A: nsel=001, loada=1 -> GET_B.
- State GET_B: nsel=100, loadb=1, shift=sh -> EXEC.
- State EXEC: shift=sh, bsel=0.
  - MOV reg: asel=1, ALUop=00.
  - All other ops: asel=0, ALUop=op.
  - CMP: loads=1, loadc=0 -> WAIT.
  - Otherwise: loadc=1 -> WRITE_REG.
- State WRITE_REG: nsel=010, vsel=00, write=1 -> WAIT.
- Latency (s accepted at edge T; w=1 again at):
  - MOV imm: T+3
  - CMP, MOV reg, MVN: T+5
  - ADD, AND: T+6
  - undefined opcode: T+2
- Handshake rules:
  - s is ignored outside WAIT.
  - in only needs to be valid in the cycle s is accepted.
  - s held high gives back-to-back instructions, each accepted on its first WAIT cycle.
- Exactly one write pulse per MOV/ADD/AND/MVN instruction, lasting one cycle. None for CMP or undefined opcodes.
- Reset mid-operation: the next state is WAIT and IR is cleared. No further strobes are issued for the aborted instruction, and reset has priority over s.
- sximm8 is combinational from IR and stable for the whole instruction.

Decomposition:
- Shared package alu_ctrl_pkg contains:
  - state encodings (WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG; 3-bit)
  - opcode/op constants
  - ALUop codes
  - nsel one-hot constants
  - vsel codes
- One sub-module: instr_dec, a purely combinational field extractor and sign-extender (IR -> opcode, op, sh, sximm8, instruction-class flags).

Test Plan:
1. Hold reset=1 for 2 cycles with s=1 -> w=1, all strobes 0, sximm8=0. Release reset -> 0x0000 is accepted as an undefined instruction and returns to WAIT after 2 cycles with no strobes.
2. in=0xD3FB (MOV R3,#-5), pulse s:
   - T+2: write=1, nsel=001, vsel=01, sximm8=0xFFFB.
   - T+3: w=1.
3. in=0xA148 (ADD R2,R1,R0,LSL):
   - GET_A: loada=1, nsel=001.
   - GET_B: loadb=1, nsel=100, shift=01.
   - EXEC: ALUop=00, asel=0, loadc=1.
   - WRITE_REG: write=1, nsel=010, vsel=00.
   - w=1 at T+6.
4. in=0xAD06 (CMP R5,R6):
   - EXEC: ALUop=01, loads=1, loadc=0.
   - write never asserted.
   - w=1 at T+5.
5. in=0xC0F4 (MOV R7,R4,sh=10):
   - loada never asserted.
   - EXEC: asel=1, ALUop=00, shift=10.
   - write with nsel=010.
   - w=1 at T+5.
6. Start ADD 0xA148 and assert reset during GET_B:
   - Next cycle: w=1, write never pulses.
   - Then hold s=1 with in=0xD3FB: two consecutive MOVs each complete in 3 cycles.
